synapse_array: RTL and testbench
================================

Name: synapse_array

Overview:
Parametrised spike-gated synaptic weight accumulator. It sweeps a banked BRAM row by row and sums the weights of active presynaptic spikes into one current per postsynaptic neuron, every ROWS_PER_NEURON rows. Weights come from one of two sources: an LFSR random-initialisation sweep, or a new host load mode with a valid/ready handshake. It sits between the spike encoder and the neuron (membrane) stage.

Parameters:
N_BANK, 6, number of BRAM banks
W_PER_BANK, 4, weight lanes per bank word
WGT_W, 16, stored weight width
WGT_MAG, 14, LFSR-generated magnitude bits (upper WGT_W-WGT_MAG bits written as 0)
DEPTH, 432, rows per sweep (multiple of ROWS_PER_NEURON)
ROWS_PER_NEURON, 24, rows accumulated per output current
ACC_W, 25, accumulator/output width
SEED_BASE, 101, LFSR seed of lane 0
SEED_STEP, 1000, seed increment per lane

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous, active-low reset
i_run  in  1  start inference sweep (IDLE only)
i_wegt_rst  in  1  start random weight init sweep (IDLE only)
i_load  in  1  start host weight load (IDLE only)
i_load_data  in  N_BANK*W_PER_BANK*WGT_W  host row data
i_load_valid  in  1  host row valid
o_load_ready  out  1  row accepted when high with valid
i_spike_bundle  in  N_BANK*W_PER_BANK  spike per lane, aligned to q
i_valid  in  1  spike bundle valid; 0 forces all spikes to 0
o_current  out  ACC_W  neuron current, 0 when o_valid low
o_valid  out  1  current valid pulse
o_is_single_done  out  1  neuron boundary pulse
o_done  out  1  one-cycle sweep complete
o_busy  out  1  state != IDLE
d  out  N_BANK*W_PER_BANK*WGT_W  BRAM write data
addr  out  N_BANK*clog2(DEPTH)  same row address replicated per bank
ce  out  N_BANK  bank enable
we  out  N_BANK  bank write enable
q  in  N_BANK*W_PER_BANK*WGT_W  BRAM read data, 1-cycle latency

Behaviour:
- FSM: IDLE, RUN, RST, LOAD, DONE. In IDLE, simultaneous commands resolve by priority run > wegt_rst > load. Commands outside IDLE are ignored.
- RUN/RST: addr_cnt increments every cycle, 0..DEPTH-1. At DEPTH-1 the FSM goes to DONE and addr_cnt returns to 0.
- LOAD: o_load_ready=1. addr_cnt increments and we=1 only on a handshake; d=i_load_data. DONE follows the handshake at DEPTH-1. A stalled host holds the FSM in LOAD indefinitely.
- DONE lasts one cycle (o_done=1), then IDLE.
- ce=1 in RUN/RST/LOAD. we=1 in RST; in LOAD, we=1 on handshake only; we=0 in RUN.
- RST: each lane has a 16-bit Fibonacci LFSR. Next state = {s[14:0], s15^s13^s12^s10}. Reset seed = SEED_BASE+lane*SEED_STEP. The LFSR advances only in RST. Lane write data = zero-extended s[WGT_MAG-1:0].
- RUN pipeline, for a row address issued at cycle t:
  - t+1: q and spikes sampled; gated lanes summed per bank.
  - t+2: bank sum registered.
  - t+3: bank accumulator updated.
- Bank accumulator: load with the sum on the first row of a neuron, otherwise add. It saturates at 2^ACC_W-1 (new behaviour; no wrap).
- Neuron boundary: row counter reaches ROWS_PER_NEURON-1 in RUN.
  - o_is_single_done pulses at t+1 after that last-row address cycle.
  - o_valid pulses at t+4, with o_current = saturated sum of all bank accumulators.
  - DEPTH/ROWS_PER_NEURON pulses per sweep (18 at defaults).
- Accumulators clear 2 cycles after DONE.
- Reset (any time, including mid-sweep): state IDLE, counters 0, LFSRs reseeded, all pipeline and accumulators 0. All outputs 0 except addr=0.

Decomposition:
- synapse_pkg: state encoding, ADDR_W=clog2(DEPTH), LANES=N_BANK*W_PER_BANK, LFSR tap constants.
- Sub-module synapse_lfsr16, one per lane, with seed parameter and advance enable.

Test Plan:
- Reset, then i_wegt_rst=1 for one cycle -> 432 write cycles, we=all 1. Lane 0 first d word = 101 & 0x3FFF; o_done 433 cycles after the command.
- i_load with host valid every other cycle; write pattern row r lane l = 1 -> exactly 432 handshakes, addresses 0..431 in order, o_done after the last one.
- RUN with all weights 1 and all spikes valid -> 18 o_valid pulses, each o_current = 24*24 = 576. The first pulse comes 4 cycles after the row-23 address cycle.
- RUN with i_valid=0 throughout -> 18 pulses of o_current=0.
- Weights 0x3FFF, all spikes, ACC_W=12 -> o_current saturates at 4095.
- i_run and i_load asserted together in IDLE -> RUN taken, o_load_ready stays 0. Reset asserted at row 200 -> all outputs 0, IDLE, a new run restarts at addr 0.

Source files
------------

// File: rtl/synapse_pkg.sv
`default_nettype none
// ============================================================================
// Module      : synapse_pkg
// Description : Shared defaults, FSM encoding and LFSR taps for synapse_array.
// Revision    : 1.0 - initial release
// ============================================================================
package synapse_pkg;

    localparam int c_DEF_N_BANK     = 6;
    localparam int c_DEF_W_PER_BANK = 4;
    localparam int c_DEF_WGT_W      = 16;
    localparam int c_DEF_WGT_MAG    = 14;
    localparam int c_DEF_DEPTH      = 432;
    localparam int c_DEF_RPN        = 24;
    localparam int c_DEF_ACC_W      = 25;

    localparam int c_ADDR_W = $clog2(c_DEF_DEPTH);
    localparam int c_LANES  = c_DEF_N_BANK * c_DEF_W_PER_BANK;

    localparam logic [2:0] c_ST_IDLE = 3'd0;
    localparam logic [2:0] c_ST_RUN  = 3'd1;
    localparam logic [2:0] c_ST_RST  = 3'd2;
    localparam logic [2:0] c_ST_LOAD = 3'd3;
    localparam logic [2:0] c_ST_DONE = 3'd4;

    // Taps at bits 15, 13, 12 and 10
    localparam logic [15:0] c_LFSR_TAPS = 16'hB400;

    function automatic logic lfsr_fb(input logic [15:0] s);
        return ^(s & c_LFSR_TAPS);
    endfunction

endpackage
`default_nettype wire

// File: rtl/synapse_array_if.sv
`default_nettype none
// ============================================================================
// Module      : synapse_array_if
// Description : Banked weight-BRAM port bundle (write data, address, enables, read data).
// Revision    : 1.0 - initial release
// ============================================================================
interface synapse_array_if
    import synapse_pkg::*;
#(
    parameter int N_BANK     = c_DEF_N_BANK,
    parameter int W_PER_BANK = c_DEF_W_PER_BANK,
    parameter int WGT_W      = c_DEF_WGT_W,
    parameter int DEPTH      = c_DEF_DEPTH
);
    localparam int c_ROW_W = N_BANK * W_PER_BANK * WGT_W;
    localparam int c_AW    = $clog2(DEPTH);

    logic [c_ROW_W-1:0]       d;
    logic [N_BANK*c_AW-1:0]   addr;
    logic [N_BANK-1:0]        ce;
    logic [N_BANK-1:0]        we;
    logic [c_ROW_W-1:0]       q;

    modport master (output d, addr, ce, we, input q);
    modport slave  (input d, addr, ce, we, output q);
endinterface
`default_nettype wire

// File: rtl/synapse_lfsr16.sv
`default_nettype none
// ============================================================================
// Module      : synapse_lfsr16
// Description : 16-bit Fibonacci LFSR with reset seed and advance enable.
// Revision    : 1.0 - initial release
// ============================================================================
module synapse_lfsr16
    import synapse_pkg::*;
#(
    parameter logic [15:0] SEED  = 16'd1,
    parameter int          OUT_W = 14
)(
    input  wire              clk,
    input  wire              reset_n,
    input  wire              i_adv,
    output logic [OUT_W-1:0] o_data
);
    logic [15:0] r_state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= SEED;
        end else if (i_adv) begin
            r_state <= {r_state[14:0], lfsr_fb(r_state)};
        end
    end

    assign o_data = r_state[OUT_W-1:0];
endmodule
`default_nettype wire

// File: rtl/synapse_array.sv
`default_nettype none
// ============================================================================
// Module      : synapse_array
// Description : Spike-gated banked weight accumulator with LFSR init and host load.
// Revision    : 1.0 - initial release
// ============================================================================
module synapse_array
    import synapse_pkg::*;
#(
    parameter int N_BANK          = c_DEF_N_BANK,
    parameter int W_PER_BANK      = c_DEF_W_PER_BANK,
    parameter int WGT_W           = c_DEF_WGT_W,
    parameter int WGT_MAG         = c_DEF_WGT_MAG,
    parameter int DEPTH           = c_DEF_DEPTH,
    parameter int ROWS_PER_NEURON = c_DEF_RPN,
    parameter int ACC_W           = c_DEF_ACC_W,
    parameter int SEED_BASE       = 101,
    parameter int SEED_STEP       = 1000
)(
    input  wire                                 clk,
    input  wire                                 reset_n,
    input  wire                                 i_run,
    input  wire                                 i_wegt_rst,
    input  wire                                 i_load,
    input  wire [N_BANK*W_PER_BANK*WGT_W-1:0]   i_load_data,
    input  wire                                 i_load_valid,
    output logic                                o_load_ready,
    input  wire [N_BANK*W_PER_BANK-1:0]         i_spike_bundle,
    input  wire                                 i_valid,
    output logic [ACC_W-1:0]                    o_current,
    output logic                                o_valid,
    output logic                                o_is_single_done,
    output logic                                o_done,
    output logic                                o_busy,
    synapse_array_if.master                     bram
);
    localparam int c_NL    = N_BANK * W_PER_BANK;
    localparam int c_AW    = $clog2(DEPTH);
    localparam int c_RW    = $clog2(ROWS_PER_NEURON + 1);
    localparam int c_SUM_W = WGT_W + $clog2(W_PER_BANK);
    localparam int c_EXT_W = ((ACC_W > c_SUM_W) ? ACC_W : c_SUM_W) + 1;
    localparam int c_TOT_W = ACC_W + $clog2(N_BANK);
    localparam logic [ACC_W-1:0] c_ACC_MAX = '1;

    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                                 input logic [c_SUM_W-1:0] s);
        logic [c_EXT_W-1:0] w_t;
        w_t = c_EXT_W'(a) + c_EXT_W'(s);
        if (w_t > c_EXT_W'(c_ACC_MAX)) return c_ACC_MAX;
        return w_t[ACC_W-1:0];
    endfunction

    logic [2:0]      r_state, w_state_nxt;
    logic [c_AW-1:0] r_addr;
    logic [c_RW-1:0] r_row;
    logic            w_addr_last, w_row_last, w_hs, w_in_run, w_in_rst, w_in_load, w_addr_adv;
    logic [c_NL*WGT_W-1:0] w_lfsr_d;

    assign w_in_run    = (r_state == c_ST_RUN);
    assign w_in_rst    = (r_state == c_ST_RST);
    assign w_in_load   = (r_state == c_ST_LOAD);
    assign w_hs        = w_in_load && i_load_valid;
    assign w_addr_last = (r_addr == c_AW'(DEPTH - 1));
    assign w_row_last  = (r_row == c_RW'(ROWS_PER_NEURON - 1));
    assign w_addr_adv  = w_in_run || w_in_rst || w_hs;

    // Run wins over weight init, which wins over host load
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (i_run)           w_state_nxt = c_ST_RUN;
                else if (i_wegt_rst) w_state_nxt = c_ST_RST;
                else if (i_load)     w_state_nxt = c_ST_LOAD;
            end
            c_ST_RUN, c_ST_RST: if (w_addr_last) w_state_nxt = c_ST_DONE;
            c_ST_LOAD:          if (w_hs && w_addr_last) w_state_nxt = c_ST_DONE;
            default:            w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_ST_IDLE;
            r_addr  <= '0;
            r_row   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_addr_adv) r_addr <= w_addr_last ? '0 : r_addr + 1'b1;
            if (w_in_run)   r_row  <= w_row_last ? '0 : r_row + 1'b1;
            else            r_row  <= '0;
        end
    end

    for (genvar l = 0; l < c_NL; l++) begin : g_lane
        logic [WGT_MAG-1:0] w_mag;
        synapse_lfsr16 #(
            .SEED  (16'(SEED_BASE + l * SEED_STEP)),
            .OUT_W (WGT_MAG)
        ) u_lfsr (
            .clk     (clk),
            .reset_n (reset_n),
            .i_adv   (w_in_rst),
            .o_data  (w_mag)
        );
        assign w_lfsr_d[l*WGT_W +: WGT_W] = WGT_W'(w_mag);
    end

    assign bram.addr = {N_BANK{r_addr}};
    assign bram.ce   = {N_BANK{w_in_run || w_in_rst || w_in_load}};
    assign bram.we   = {N_BANK{w_in_rst || w_hs}};
    assign bram.d    = w_in_rst ? w_lfsr_d : (w_in_load ? i_load_data : '0);

    assign o_load_ready = w_in_load;
    assign o_busy       = (r_state != c_ST_IDLE);
    assign o_done       = (r_state == c_ST_DONE);

    // Stage tags follow each issued row through the read/sum/accumulate pipeline
    logic                 r_p1_valid, r_p1_first, r_p1_last;
    logic                 r_p2_valid, r_p2_first, r_p2_last;
    logic                 r_p3_last;
    logic                 r_done_d1, r_done_d2;
    logic [c_SUM_W-1:0]   w_bank_sum [N_BANK];
    logic [c_SUM_W-1:0]   r_bank_sum [N_BANK];
    logic [ACC_W-1:0]     r_acc      [N_BANK];
    logic [c_TOT_W-1:0]   w_total;
    logic [ACC_W-1:0]     w_total_sat;
    logic [ACC_W-1:0]     r_current;
    logic                 r_valid;

    always_comb begin
        for (int b = 0; b < N_BANK; b++) begin
            w_bank_sum[b] = '0;
            for (int l = 0; l < W_PER_BANK; l++) begin
                if (i_valid && i_spike_bundle[b*W_PER_BANK + l])
                    w_bank_sum[b] = w_bank_sum[b]
                                  + c_SUM_W'(bram.q[(b*W_PER_BANK + l)*WGT_W +: WGT_W]);
            end
        end
    end

    always_comb begin
        w_total = '0;
        for (int b = 0; b < N_BANK; b++) w_total = w_total + c_TOT_W'(r_acc[b]);
        w_total_sat = (w_total > c_TOT_W'(c_ACC_MAX)) ? c_ACC_MAX : w_total[ACC_W-1:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_p1_valid <= 1'b0;  r_p1_first <= 1'b0;  r_p1_last <= 1'b0;
            r_p2_valid <= 1'b0;  r_p2_first <= 1'b0;  r_p2_last <= 1'b0;
            r_p3_last  <= 1'b0;
            r_done_d1  <= 1'b0;  r_done_d2  <= 1'b0;
            r_current  <= '0;    r_valid    <= 1'b0;
            for (int b = 0; b < N_BANK; b++) begin
                r_bank_sum[b] <= '0;
                r_acc[b]      <= '0;
            end
        end else begin
            r_p1_valid <= w_in_run;
            r_p1_first <= w_in_run && (r_row == '0);
            r_p1_last  <= w_in_run && w_row_last;
            r_p2_valid <= r_p1_valid;
            r_p2_first <= r_p1_first;
            r_p2_last  <= r_p1_last;
            r_p3_last  <= r_p2_valid && r_p2_last;
            r_done_d1  <= o_done;
            r_done_d2  <= r_done_d1;
            for (int b = 0; b < N_BANK; b++) begin
                r_bank_sum[b] <= r_p1_valid ? w_bank_sum[b] : '0;
                if (r_done_d2)
                    r_acc[b] <= '0;
                else if (r_p2_valid)
                    r_acc[b] <= sat_add(r_p2_first ? '0 : r_acc[b], r_bank_sum[b]);
            end
            r_valid   <= r_p3_last;
            r_current <= r_p3_last ? w_total_sat : '0;
        end
    end

    assign o_is_single_done = r_p1_last;
    assign o_valid          = r_valid;
    assign o_current        = r_current;
endmodule
`default_nettype wire

// File: tb/tb_synapse_array.sv
`default_nettype none
// ============================================================================
// Module      : tb_synapse_array
// Description : Directed self-checking bench for synapse_array (default and ACC_W=12).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_synapse_array;
    localparam int c_ROW_W = 384;
    localparam int c_AW    = 9;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic                 i_run, i_wegt_rst, i_load, i_load_valid, i_valid;
    logic [c_ROW_W-1:0]   i_load_data;
    logic [23:0]          i_spike_bundle;
    logic                 o_load_ready, o_valid, o_is_single_done, o_done, o_busy;
    logic [24:0]          o_current;
    logic                 s_load_ready, s_valid, s_single_done, s_done, s_busy;
    logic [11:0]          s_current;
    logic [c_ROW_W-1:0]   q_r;
    logic [c_ROW_W-1:0]   mem [0:511];

    int n_tests = 0;
    int n_fail  = 0;

    synapse_array_if bif ();
    synapse_array_if bif_s ();

    always #5 clk = ~clk;

    synapse_array dut (
        .clk(clk), .reset_n(reset_n), .i_run(i_run), .i_wegt_rst(i_wegt_rst),
        .i_load(i_load), .i_load_data(i_load_data), .i_load_valid(i_load_valid),
        .o_load_ready(o_load_ready), .i_spike_bundle(i_spike_bundle), .i_valid(i_valid),
        .o_current(o_current), .o_valid(o_valid), .o_is_single_done(o_is_single_done),
        .o_done(o_done), .o_busy(o_busy), .bram(bif)
    );

    synapse_array #(.ACC_W(12)) dut_s (
        .clk(clk), .reset_n(reset_n), .i_run(i_run), .i_wegt_rst(i_wegt_rst),
        .i_load(i_load), .i_load_data(i_load_data), .i_load_valid(i_load_valid),
        .o_load_ready(s_load_ready), .i_spike_bundle(i_spike_bundle), .i_valid(i_valid),
        .o_current(s_current), .o_valid(s_valid), .o_is_single_done(s_single_done),
        .o_done(s_done), .o_busy(s_busy), .bram(bif_s)
    );

    // Banked BRAM with one-cycle read latency; both instances issue identical addresses
    always @(posedge clk) begin
        for (int b = 0; b < 6; b++) begin
            if (bif.ce[b]) begin
                if (bif.we[b]) mem[bif.addr[b*c_AW +: c_AW]][b*64 +: 64] <= bif.d[b*64 +: 64];
                q_r[b*64 +: 64] <= mem[bif.addr[b*c_AW +: c_AW]][b*64 +: 64];
            end
        end
    end
    assign bif.q   = q_r;
    assign bif_s.q = q_r;

    task automatic test_reset;
        reset_n = 1'b0;
        @(negedge clk); @(negedge clk); #1;
        n_tests++;
        if ({o_valid, o_is_single_done, o_done, o_busy, o_load_ready} !== 5'b0) begin
            n_fail++; $display("FAIL reset_flags got=%b want=00000",
                {o_valid, o_is_single_done, o_done, o_busy, o_load_ready});
        end
        n_tests++;
        if (o_current !== 25'd0) begin
            n_fail++; $display("FAIL reset_current got=%0d want=0", o_current);
        end
        n_tests++;
        if ({bif.ce, bif.we} !== 12'd0 || bif.addr !== '0 || bif.d !== '0) begin
            n_fail++; $display("FAIL reset_bram ce=%h we=%h addr=%h want all 0", bif.ce, bif.we, bif.addr);
        end
        @(negedge clk); reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_wegt_rst;
        logic [15:0] s0, s23;
        int d_err, we_err, a_err, done_k;
        logic [15:0] first_d;
        s0 = 16'd101; s23 = 16'd23101;
        d_err = 0; we_err = 0; a_err = 0; done_k = -1; first_d = '0;
        @(negedge clk); i_wegt_rst = 1'b1;
        for (int k = 1; k <= 500; k++) begin
            @(negedge clk); i_wegt_rst = 1'b0; #1;
            if (o_done) begin done_k = k; break; end
            if (k == 1) first_d = bif.d[15:0];
            if (bif.d[15:0] !== {2'b00, s0[13:0]} || bif.d[383:368] !== {2'b00, s23[13:0]}) d_err++;
            if (bif.we !== 6'h3F || bif.ce !== 6'h3F) we_err++;
            if (bif.addr[c_AW-1:0] !== 9'(k - 1)) a_err++;
            s0  = {s0[14:0],  s0[15]  ^ s0[13]  ^ s0[12]  ^ s0[10]};
            s23 = {s23[14:0], s23[15] ^ s23[13] ^ s23[12] ^ s23[10]};
        end
        n_tests++;
        if (first_d !== 16'd101) begin n_fail++; $display("FAIL wegt_first_d got=%0d want=101", first_d); end
        n_tests++;
        if (d_err != 0) begin n_fail++; $display("FAIL wegt_lfsr_data bad_cycles=%0d want=0", d_err); end
        n_tests++;
        if (we_err != 0) begin n_fail++; $display("FAIL wegt_we_ce bad_cycles=%0d want=0", we_err); end
        n_tests++;
        if (a_err != 0) begin n_fail++; $display("FAIL wegt_addr bad_cycles=%0d want=0", a_err); end
        n_tests++;
        if (done_k != 433) begin n_fail++; $display("FAIL wegt_done_cycle got=%0d want=433", done_k); end
        @(negedge clk); #1;
        n_tests++;
        if (o_busy !== 1'b0) begin n_fail++; $display("FAIL wegt_idle busy=%b want=0", o_busy); end
    endtask

    task automatic test_load(input logic [15:0] wval);
        int hs, last_hs_k, done_k, a_err, w_err;
        hs = 0; last_hs_k = -1; done_k = -1; a_err = 0; w_err = 0;
        i_load_data = {24{wval}};
        @(negedge clk); i_load = 1'b1;
        for (int k = 1; k <= 2000; k++) begin
            @(negedge clk); i_load = 1'b0; i_load_valid = (k % 2 == 0); #1;
            if (o_done) begin done_k = k; break; end
            if (o_load_ready !== 1'b1) w_err++;
            if (i_load_valid) begin
                if (bif.addr[c_AW-1:0] !== 9'(hs) || bif.d !== i_load_data) a_err++;
                if (bif.we !== 6'h3F) w_err++;
                hs++; last_hs_k = k;
            end else if (bif.we !== 6'h00) begin
                w_err++;
            end
        end
        i_load_valid = 1'b0;
        n_tests++;
        if (hs != 432) begin n_fail++; $display("FAIL load_handshakes got=%0d want=432", hs); end
        n_tests++;
        if (a_err != 0) begin n_fail++; $display("FAIL load_addr_data bad=%0d want=0", a_err); end
        n_tests++;
        if (w_err != 0) begin n_fail++; $display("FAIL load_we_ready bad=%0d want=0", w_err); end
        n_tests++;
        if (done_k != last_hs_k + 1) begin
            n_fail++; $display("FAIL load_done_cycle got=%0d want=%0d", done_k, last_hs_k + 1);
        end
        @(negedge clk);
    endtask

    task automatic test_run(input logic vin, input int exp_cur, input int exp_cur_s);
        int pulses, pulses_s, first_v, first_sd, done_k, z_err;
        pulses = 0; pulses_s = 0; first_v = -1; first_sd = -1; done_k = -1; z_err = 0;
        i_valid = vin; i_spike_bundle = '1;
        @(negedge clk); i_run = 1'b1;
        for (int k = 1; k <= 600; k++) begin
            @(negedge clk); i_run = 1'b0; #1;
            if (o_is_single_done && first_sd < 0) first_sd = k;
            if (o_done && done_k < 0) done_k = k;
            if (o_valid) begin
                if (first_v < 0) first_v = k;
                pulses++;
                n_tests++;
                if (o_current !== 25'(exp_cur)) begin
                    n_fail++; $display("FAIL run_current pulse=%0d got=%0d want=%0d", pulses, o_current, exp_cur);
                end
            end else if (o_current !== 25'd0) begin
                z_err++;
            end
            if (s_valid) begin
                pulses_s++;
                n_tests++;
                if (s_current !== 12'(exp_cur_s)) begin
                    n_fail++; $display("FAIL run_current_acc12 pulse=%0d got=%0d want=%0d", pulses_s, s_current, exp_cur_s);
                end
            end
            if (done_k > 0 && k >= done_k + 6) break;
        end
        n_tests++;
        if (pulses != 18 || pulses_s != 18) begin
            n_fail++; $display("FAIL run_pulse_count got=%0d/%0d want=18", pulses, pulses_s);
        end
        n_tests++;
        if (first_v != 28) begin n_fail++; $display("FAIL run_first_valid_cycle got=%0d want=28", first_v); end
        n_tests++;
        if (first_sd != 25) begin n_fail++; $display("FAIL run_single_done_cycle got=%0d want=25", first_sd); end
        n_tests++;
        if (done_k != 433) begin n_fail++; $display("FAIL run_done_cycle got=%0d want=433", done_k); end
        n_tests++;
        if (z_err != 0) begin n_fail++; $display("FAIL run_current_idle_zero bad=%0d want=0", z_err); end
        i_valid = 1'b0; i_spike_bundle = '0;
    endtask

    task automatic test_priority_midreset;
        int lr_err, done_k;
        logic found;
        lr_err = 0; done_k = -1; found = 1'b0;
        i_valid = 1'b1; i_spike_bundle = '1;
        @(negedge clk); i_run = 1'b1; i_load = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk); i_run = 1'b0; #1;
            if (o_load_ready !== 1'b0 || o_busy !== 1'b1 || bif.we !== 6'h0 || bif.ce !== 6'h3F) lr_err++;
        end
        i_load = 1'b0;
        n_tests++;
        if (lr_err != 0) begin n_fail++; $display("FAIL prio_run_over_load bad=%0d want=0", lr_err); end
        for (int j = 0; j < 300 && !found; j++) begin
            @(negedge clk); #1;
            if (bif.addr[c_AW-1:0] == 9'd200) found = 1'b1;
        end
        n_tests++;
        if (!found) begin n_fail++; $display("FAIL midreset_reach_row200 got=0 want=1"); end
        reset_n = 1'b0; #1;
        n_tests++;
        if ({o_valid, o_is_single_done, o_done, o_busy, o_load_ready} !== 5'b0 || o_current !== 25'd0 ||
            bif.ce !== 6'h0 || bif.we !== 6'h0 || bif.addr !== '0 || bif.d !== '0) begin
            n_fail++; $display("FAIL midreset_outputs busy=%b ce=%h addr=%h cur=%0d want all 0",
                o_busy, bif.ce, bif.addr, o_current);
        end
        @(negedge clk); reset_n = 1'b1;
        @(negedge clk); i_run = 1'b1;
        @(negedge clk); i_run = 1'b0; #1;
        n_tests++;
        if (bif.addr[c_AW-1:0] !== 9'd0 || o_busy !== 1'b1) begin
            n_fail++; $display("FAIL restart_addr0 got=%0d busy=%b want=0 busy=1", bif.addr[c_AW-1:0], o_busy);
        end
        @(negedge clk); #1;
        n_tests++;
        if (bif.addr[c_AW-1:0] !== 9'd1) begin
            n_fail++; $display("FAIL restart_addr1 got=%0d want=1", bif.addr[c_AW-1:0]);
        end
        for (int k = 0; k < 600 && done_k < 0; k++) begin
            @(negedge clk); #1;
            if (o_done) done_k = k;
        end
        n_tests++;
        if (done_k < 0) begin n_fail++; $display("FAIL restart_done got=timeout want=done"); end
    endtask

    initial begin
        reset_n = 1'b0; i_run = 1'b0; i_wegt_rst = 1'b0; i_load = 1'b0;
        i_load_valid = 1'b0; i_load_data = '0; i_spike_bundle = '0; i_valid = 1'b0;
        test_reset();
        test_wegt_rst();
        test_load(16'd1);
        test_run(1'b1, 576, 576);
        test_run(1'b0, 0, 0);
        test_load(16'h3FFF);
        test_run(1'b1, 9436608, 4095);
        test_priority_midreset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
